led_scan_ctrl: RTL
==================

LED_SCAN_CTRL -- requirements
Module: led_scan_ctrl

Interface
REQ-001 SHALL have parameter REFRESH_CYCLES, default 1024, clocks each digit is lit (min 2).
REQ-002 SHALL have parameter BLANK_CYCLES, default 16, clocks all anodes are off between digits, for anti-ghosting (min 1).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en  input  1  scan enable.
REQ-006 SHALL have port load_valid  input  1  new display value offered.
REQ-007 SHALL have port load_data  input  16  four hex nibbles; [3:0] is digit 0 (rightmost).
REQ-008 SHALL have port load_ready  output  1  high when no update is pending.
REQ-009 SHALL have port char  output  4  nibble for the external 4-to-7-segment decoder.
REQ-010 SHALL have port an  output  4  active-low one-hot anode select; 4'b1111 means all off.
REQ-011 SHALL have port frame_start  output  1  one-clock pulse when digit 0 begins lighting.

Function
REQ-012 SHALL implement a two-state FSM: BLANK (an=4'b1111, BLANK_CYCLES clocks) and SHOW (an[idx]=0, others 1, REFRESH_CYCLES clocks).
REQ-013 SHALL use a 2-bit digit index idx: BLANK->SHOW keeps idx; SHOW->BLANK increments idx, wrapping 3->0.
REQ-014 SHALL register all outputs; char = active[4*idx+3:4*idx] for the current idx, valid in both states.
REQ-015 SHALL make one frame exactly 4*(REFRESH_CYCLES+BLANK_CYCLES) clocks while en=1.
REQ-016 SHALL accept load_data into a pending register on a cycle with load_valid=1 and load_ready=1, then drop load_ready the next cycle.
REQ-017 SHALL ignore load_valid while load_ready=0; the pending value is never overwritten.
REQ-018 SHALL copy pending into the active register only on the BLANK->SHOW transition with idx=0, so no frame mixes old and new digits.
REQ-019 SHALL raise load_ready again in the same cycle the copy occurs.
REQ-020 SHALL handle a load accepted in the same cycle as a frame boundary by holding it pending until the next frame boundary.
REQ-021 SHALL drive frame_start=1 for exactly the first SHOW cycle of idx=0.
REQ-022 SHALL, when en=0: force state BLANK, idx=0, counter=0, an=4'b1111, frame_start=0; the load handshake stays operational.
REQ-023 SHALL, after en rises, spend a full BLANK_CYCLES in BLANK before SHOW idx=0.
REQ-024 SHALL size the cycle counter as clog2 of max(REFRESH_CYCLES, BLANK_CYCLES) bits, counting from 0 to N-1 with no overflow.

Reset
REQ-025 SHALL, on rst_n=0, immediately set: state BLANK, idx=0, counter=0, an=4'b1111, char=0, frame_start=0, load_ready=1, active=16'h0000, pending empty.
REQ-026 SHALL, on reset mid-frame or with a load pending, discard the pending data and restart per REQ-023 after rst_n rises.

Configuration
REQ-027 SHALL, with macro LEADING_ZERO_BLANK_EN defined, keep an=4'b1111 during SHOW of digit i (i>0) when active nibbles i..3 are all zero; timing, idx and char are unchanged.
REQ-028 SHALL, without LEADING_ZERO_BLANK_EN, light every digit during its SHOW regardless of value.

Verification (REFRESH_CYCLES=8, BLANK_CYCLES=2)
REQ-029 SHALL cover: reset release, en=1 -> an=1111 for 2 clks, then 1110 for 8, 1111 for 2, 1101 for 8, ... and frame_start every 40 clks.
REQ-030 SHALL cover: load 16'h1234 mid-frame -> load_ready=0 until the next frame start; char sequence 4,3,2,1 from that frame on.
REQ-031 SHALL cover: second load 16'hABCD while pending -> ignored; display 16'h1234.
REQ-032 SHALL cover: load coinciding with the frame boundary -> applied one frame (40 clks) later.
REQ-033 SHALL cover: rst_n pulsed low during SHOW idx=2 with a load pending -> an=1111 asynchronously, active=0, load_ready=1.
REQ-034 SHALL cover: with LEADING_ZERO_BLANK_EN, active=16'h0050 -> digits 2 and 3 stay dark, digits 0 and 1 light; with active=0 only digit 0 lights.

Source files
------------

// File: rtl/led_scan_ctrl.sv
// rtl/led_scan_ctrl.sv - four-digit multiplexed LED scan controller with frame-synchronous display update
// Optional feature: define LEADING_ZERO_BLANK_EN to keep leading-zero digits dark.
module led_scan_ctrl #(
    parameter int REFRESH_CYCLES = 1024,
    parameter int BLANK_CYCLES   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        load_valid,
    input  logic [15:0] load_data,
    output logic        load_ready,
    output logic [3:0]  char,
    output logic [3:0]  an,
    output logic        frame_start
);

    localparam int MAXC = (REFRESH_CYCLES > BLANK_CYCLES) ? REFRESH_CYCLES : BLANK_CYCLES;
    localparam int CW   = $clog2(MAXC);
    localparam logic [CW-1:0] R_LAST = CW'(REFRESH_CYCLES - 1);
    localparam logic [CW-1:0] B_LAST = CW'(BLANK_CYCLES - 1);

    typedef enum logic {BLANK = 1'b0, SHOW = 1'b1} state_t;

    state_t          state, state_n;
    logic [1:0]      idx, idx_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [15:0]     active, active_n, pending;
    logic            copy, accept, frame_enter;
    logic [3:0]      an_n, char_n;
    logic            fs_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BLANK;
            idx   <= 2'd0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt + 1'b1;
        if (!en) begin
            state_n = BLANK;
            idx_n   = 2'd0;
            cnt_n   = '0;
        end else begin
            case (state)
                BLANK: if (cnt == B_LAST) begin
                    state_n = SHOW;
                    cnt_n   = '0;
                end
                SHOW: if (cnt == R_LAST) begin
                    state_n = BLANK;
                    cnt_n   = '0;
                    idx_n   = idx + 2'd1;
                end
                default: state_n = BLANK;
            endcase
        end
    end

    // The only point where a new value may take effect is entry into digit 0.
    assign frame_enter = (state == BLANK) && (state_n == SHOW) && (idx == 2'd0);
    assign copy        = frame_enter && !load_ready;
    assign accept      = load_valid && load_ready;
    assign active_n    = copy ? pending : active;

    always_comb begin
        char_n = active_n[{idx_n, 2'b00} +: 4];
        fs_n   = frame_enter;
        an_n   = 4'b1111;
        if (state_n == SHOW) begin
            an_n = ~(4'b0001 << idx_n);
`ifdef LEADING_ZERO_BLANK_EN
            if ((idx_n != 2'd0) && ((active_n >> {idx_n, 2'b00}) == 16'h0000))
                an_n = 4'b1111;
`endif
        end
    end

    // load_ready doubles as "pending empty"; copy and accept are mutually exclusive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active     <= 16'h0000;
            pending    <= 16'h0000;
            load_ready <= 1'b1;
        end else begin
            active <= active_n;
            if (copy)
                load_ready <= 1'b1;
            else if (accept) begin
                pending    <= load_data;
                load_ready <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an          <= 4'b1111;
            char        <= 4'h0;
            frame_start <= 1'b0;
        end else begin
            an          <= an_n;
            char        <= char_n;
            frame_start <= fs_n;
        end
    end

endmodule
